// File: rtl/rfphoenix_mem_req_queue.sv
// In-order memory request queue between the issue logic and the data-cache unit.
// Each accepted request is stamped with a sequential transaction id. A flush can kill
// every queued request of one reorder entry. Killed entries keep their slot until they
// reach the head, where they are silently dropped.
//
// Request layout (389 bits, MSB first):
//   tid[7:0] | rid[3:0] | we | op[3:0] | addr[63:0] | data[255:0] | be[31:0] | user[19:0]
module rfphoenix_mem_req_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_v_i,
  input  logic [388:0] req_i,
  output logic         req_rdy_o,
  output logic         mem_v_o,
  output logic [388:0] mem_req_o,
  input  logic         mem_ack_i,
  input  logic         kill_v_i,
  input  logic [3:0]   kill_rid_i,
  output logic [4:0]   count_o,
  output logic         empty_o,
  output logic         full_o
);

  typedef struct packed {
    logic [7:0]   tid;
    logic [3:0]   rid;
    logic         we;
    logic [3:0]   op;
    logic [63:0]  addr;
    logic [255:0] data;
    logic [31:0]  be;
    logic [19:0]  user;
  } mem_req_t;

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mem_req_t             mem_q [DEPTH];
  logic [DEPTH-1:0]     alive_q, alive_d;
  logic [AW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [4:0]           count_q, count_d;
  logic [7:0]           tid_q, tid_d;

  mem_req_t req_in, req_stamped;
  logic     push, pop, xfer, discard, head_alive, not_empty;

  assign req_in = mem_req_t'(req_i);

  // Head presentation and handshake decode, all from registered state.
  always_comb begin
    not_empty   = (count_q != 5'd0);
    full_o      = (count_q == 5'(DEPTH));
    empty_o     = ~not_empty;
    count_o     = count_q;
    req_rdy_o   = ~full_o;
    head_alive  = alive_q[head_q];
    mem_v_o     = not_empty & head_alive;
    mem_req_o   = mem_v_o ? 389'(mem_q[head_q]) : '0;
    push        = req_v_i & ~full_o;
    xfer        = mem_v_o & mem_ack_i;
    discard     = not_empty & ~head_alive;
    pop         = xfer | discard;
    req_stamped = req_in;
    req_stamped.tid = tid_q;
  end

  // Next-state: pointers, count, tid counter and alive bits.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    tid_d   = tid_q;
    alive_d = alive_q;
    count_d = count_q + 5'(push) - 5'(pop);
    if (pop) begin
      // Clearing on pop keeps unoccupied slots dead, so the kill scan needs no range check.
      alive_d[head_q] = 1'b0;
      head_d          = head_q + AW'(1);
    end
    if (kill_v_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (mem_q[i].rid == kill_rid_i) alive_d[i] = 1'b0;
      end
    end
    // A push never targets the head being popped: that would need count 0 (no pop) or
    // full (no push).
    if (push) begin
      alive_d[tail_q] = ~(kill_v_i && (req_in.rid == kill_rid_i));
      tail_d          = tail_q + AW'(1);
      tid_d           = tid_q + 8'd1;
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      tid_q   <= '0;
      alive_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      tid_q   <= tid_d;
      alive_q <= alive_d;
    end
  end

  // Payload storage; contents are masked by the alive bits so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= req_stamped;
  end

endmodule

// File: tb/tb_rfphoenix_mem_req_queue.sv
// Self-checking bench: a queue-of-entries model predicts head, count and flags every cycle.
module tb_rfphoenix_mem_req_queue;

  localparam int unsigned DEPTH = 8;

  typedef struct packed {
    logic [7:0]   tid;
    logic [3:0]   rid;
    logic         we;
    logic [3:0]   op;
    logic [63:0]  addr;
    logic [255:0] data;
    logic [31:0]  be;
    logic [19:0]  user;
  } req_t;

  typedef struct {
    req_t req;
    logic alive;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_v_i = 1'b0;
  logic [388:0] req_i = '0;
  logic         req_rdy_o;
  logic         mem_v_o;
  logic [388:0] mem_req_o;
  logic         mem_ack_i = 1'b0;
  logic         kill_v_i = 1'b0;
  logic [3:0]   kill_rid_i = '0;
  logic [4:0]   count_o;
  logic         empty_o;
  logic         full_o;

  int   n_checks = 0;
  int   n_fails  = 0;
  ent_t mq[$];
  logic [7:0] tid_m = 8'h00;

  always #5 clk = ~clk;

  rfphoenix_mem_req_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_v_i    (req_v_i),
    .req_i      (req_i),
    .req_rdy_o  (req_rdy_o),
    .mem_v_o    (mem_v_o),
    .mem_req_o  (mem_req_o),
    .mem_ack_i  (mem_ack_i),
    .kill_v_i   (kill_v_i),
    .kill_rid_i (kill_rid_i),
    .count_o    (count_o),
    .empty_o    (empty_o),
    .full_o     (full_o)
  );

  task automatic check_eq(input string tag, input logic [388:0] got, input logic [388:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic req_t make_req(input logic [3:0] rid);
    req_t r;
    r.tid  = 8'($urandom);
    r.rid  = rid;
    r.we   = 1'($urandom);
    r.op   = 4'($urandom);
    r.addr = {$urandom, $urandom};
    for (int k = 0; k < 8; k++) r.data[k*32 +: 32] = $urandom;
    r.be   = $urandom;
    r.user = 20'($urandom);
    return r;
  endfunction

  // Drive one cycle at the negedge, compare outputs with the model, advance the model.
  task automatic step(input logic pv, input req_t r, input logic ack, input logic kv,
                      input logic [3:0] kr);
    logic         exp_v, xfer, discard, push, killed;
    logic [388:0] exp_req;
    ent_t         e;
    req_v_i = pv; req_i = r; mem_ack_i = ack; kill_v_i = kv; kill_rid_i = kr;
    #1;
    exp_v   = (mq.size() != 0) && mq[0].alive;
    exp_req = '0;
    if (exp_v) exp_req = mq[0].req;
    check_eq("mem_v", mem_v_o, exp_v);
    check_eq("mem_req", mem_req_o, exp_req);
    check_eq("count", count_o, mq.size());
    check_eq("empty", empty_o, mq.size() == 0);
    check_eq("full", full_o, mq.size() == DEPTH);
    check_eq("req_rdy", req_rdy_o, mq.size() != DEPTH);
    xfer    = exp_v && ack;
    discard = (mq.size() != 0) && !mq[0].alive;
    push    = pv && (mq.size() < DEPTH);
    if (xfer || discard) void'(mq.pop_front());
    if (kv) begin
      for (int i = 0; i < mq.size(); i++) if (mq[i].req.rid == kr) mq[i].alive = 1'b0;
    end
    if (push) begin
      killed      = kv && (r.rid == kr);
      e.req       = r;
      e.req.tid   = tid_m;
      e.alive     = !killed;
      mq.push_back(e);
      tid_m       = tid_m + 8'd1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic ack);
    step(1'b0, '0, ack, 1'b0, 4'd0);
  endtask

  task automatic push_one(input logic [3:0] rid, input logic ack);
    step(1'b1, make_req(rid), ack, 1'b0, 4'd0);
  endtask

  task automatic drain();
    for (int n = 0; n < 2 * DEPTH + 4 && mq.size() != 0; n++) idle(1'b1);
    idle(1'b0);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    req_v_i = 1'b0; mem_ack_i = 1'b0; kill_v_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mem_v", mem_v_o, 1'b0);
    check_eq("rst_count", count_o, 5'd0);
    check_eq("rst_mem_req", mem_req_o, '0);
    check_eq("rst_empty", empty_o, 1'b1);
    check_eq("rst_full", full_o, 1'b0);
    check_eq("rst_rdy", req_rdy_o, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    tid_m = 8'h00;
  endtask

  initial begin
    req_t r9;
    @(negedge clk);
    do_reset();

    // 1: three pushes, then ack in order
    push_one(4'd1, 1'b0);
    push_one(4'd2, 1'b0);
    push_one(4'd3, 1'b0);
    check_eq("t1_tid0", mem_req_o[388:381], 8'h00);
    drain();

    // 2: fill, refuse while full even with a pop, accept next cycle; pointers wrap
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_one(4'(i), 1'b0);
    r9 = make_req(4'd9);
    step(1'b1, r9, 1'b1, 1'b0, 4'd0);
    step(1'b1, r9, 1'b0, 1'b0, 4'd0);
    push_one(4'd10, 1'b0);
    idle(1'b1);
    push_one(4'd11, 1'b1);
    drain();

    // 3: kill rid 5 among 5,6,5,7
    push_one(4'd5, 1'b0);
    push_one(4'd6, 1'b0);
    push_one(4'd5, 1'b0);
    push_one(4'd7, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 4'd5);
    for (int i = 0; i < 4; i++) idle(1'b1);
    check_eq("t3_count", count_o, 5'd0);
    idle(1'b0);

    // 4: kill rid 4 with a rid-4 head transfer and a rid-4 push in the same cycle
    push_one(4'd4, 1'b0);
    push_one(4'd2, 1'b0);
    step(1'b1, make_req(4'd4), 1'b1, 1'b1, 4'd4);
    push_one(4'd3, 1'b0);
    drain();

    // 5: 260 pushes with continuous ack; tid wraps
    do_reset();
    push_one(4'd0, 1'b0);
    for (int i = 1; i < 260; i++) push_one(4'(i), 1'b1);
    drain();

    // 6: reset with entries queued, then first tid restarts at zero
    for (int i = 0; i < 5; i++) push_one(4'(i), 1'b0);
    check_eq("t6_mem_v_before", mem_v_o, 1'b1);
    do_reset();
    push_one(4'd8, 1'b0);
    check_eq("t6_tid0", mem_req_o[388:381], 8'h00);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
